// File: rtl/fpu_convert.sv
// rtl/fpu_convert.sv - IEEE-754 single <-> 32-bit integer converter, truncating, iterative shifter
// Optional single-pass barrel shifter build: define FPU_CONVERT_FAST_EN.
module fpu_convert (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        OP,
    input  logic        SIGNED,
    input  logic [31:0] OPERAND,
    output logic [31:0] RESULT,
    output logic        BUSY,
    output logic        DONE,
    output logic        EXCEPTION
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PACK,
        S_DONE
    } state_t;

    state_t      state;
    logic [31:0] sreg;
    logic [4:0]  kexp;
    logic        op_r;
    logic        neg_r;
    logic        raw_r;
    logic        exc_r;
`ifndef FPU_CONVERT_FAST_EN
    logic [4:0]  cnt;
`endif

    logic [7:0]  in_e;
    logic [22:0] in_f;
    logic        in_s;
    logic        i_neg;
    logic [31:0] i_mag;

    logic [31:0] ld_reg;
    logic [4:0]  ld_k;
    logic        ld_raw;
    logic        ld_exc;
    logic        ld_neg;

    logic [31:0] sh;
    logic [31:0] pk_res;

    function automatic logic [4:0] lzc32(input logic [31:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n = 5'(31 - i);
        end
        return n;
    endfunction

    assign in_e = OPERAND[30:23];
    assign in_f = OPERAND[22:0];
    assign in_s = OPERAND[31];

    // Operand classification at accept: special cases load the final value
    // straight into the shift register and bypass the pack arithmetic.
    always_comb begin
        ld_reg = 32'h0;
        ld_k   = 5'd0;
        ld_raw = 1'b0;
        ld_exc = 1'b0;
        ld_neg = 1'b0;
        i_neg  = SIGNED & OPERAND[31];
        i_mag  = i_neg ? (~OPERAND + 32'd1) : OPERAND;
        if (!OP) begin
            ld_neg = i_neg;
            if (i_mag == 32'h0) begin
                ld_raw = 1'b1;
            end else begin
                ld_reg = i_mag;
                ld_k   = lzc32(i_mag);
            end
        end else begin
            ld_neg = in_s;
            if (in_e == 8'hFF && in_f != 23'h0) begin
                ld_raw = 1'b1;
                ld_exc = 1'b1;
                ld_reg = SIGNED ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            end else if (in_e < 8'd127) begin
                ld_raw = 1'b1;
            end else if (SIGNED && in_e >= 8'd158) begin
                ld_raw = 1'b1;
                if (OPERAND == 32'hCF00_0000) begin
                    ld_reg = 32'h8000_0000;
                end else begin
                    ld_exc = 1'b1;
                    ld_reg = in_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                end
            end else if (!SIGNED && in_s) begin
                ld_raw = 1'b1;
                ld_exc = 1'b1;
            end else if (!SIGNED && in_e >= 8'd159) begin
                ld_raw = 1'b1;
                ld_exc = 1'b1;
                ld_reg = 32'hFFFF_FFFF;
            end else begin
                ld_reg = {1'b1, in_f, 8'h00};
                ld_k   = 5'(8'd158 - in_e);
            end
        end
    end

    always_comb begin
`ifdef FPU_CONVERT_FAST_EN
        sh = op_r ? (sreg >> kexp) : (sreg << kexp);
`else
        sh = sreg;
`endif
        if (raw_r) begin
            pk_res = sreg;
        end else if (!op_r) begin
            pk_res = {neg_r, 8'd158 - {3'b000, kexp}, sh[30:8]};
        end else begin
            pk_res = neg_r ? (~sh + 32'd1) : sh;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            sreg      <= 32'h0;
            kexp      <= 5'd0;
            op_r      <= 1'b0;
            neg_r     <= 1'b0;
            raw_r     <= 1'b0;
            exc_r     <= 1'b0;
            RESULT    <= 32'h0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            EXCEPTION <= 1'b0;
`ifndef FPU_CONVERT_FAST_EN
            cnt       <= 5'd0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        sreg  <= ld_reg;
                        kexp  <= ld_k;
                        op_r  <= OP;
                        neg_r <= ld_neg;
                        raw_r <= ld_raw;
                        exc_r <= ld_exc;
                        BUSY  <= 1'b1;
`ifdef FPU_CONVERT_FAST_EN
                        state <= S_PACK;
`else
                        cnt   <= ld_k;
                        state <= (ld_raw || ld_k == 5'd0) ? S_PACK : S_SHIFT;
`endif
                    end
                end
`ifndef FPU_CONVERT_FAST_EN
                S_SHIFT: begin
                    sreg <= op_r ? (sreg >> 1) : (sreg << 1);
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) state <= S_PACK;
                end
`endif
                S_PACK: begin
                    RESULT    <= pk_res;
                    EXCEPTION <= exc_r;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_convert.sv
// tb/tb_fpu_convert.sv - randomized and directed bench for fpu_convert against a real-arithmetic model
module tb_fpu_convert;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        OP = 1'b0;
    logic        SIGNED = 1'b0;
    logic [31:0] OPERAND = 32'h0;
    logic [31:0] RESULT;
    logic        BUSY;
    logic        DONE;
    logic        EXCEPTION;

    int pass_cnt = 0;
    int total_cnt = 0;

    fpu_convert dut (
        .CLK(clk),
        .RESET(RESET),
        .START(START),
        .OP(OP),
        .SIGNED(SIGNED),
        .OPERAND(OPERAND),
        .RESULT(RESULT),
        .BUSY(BUSY),
        .DONE(DONE),
        .EXCEPTION(EXCEPTION)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic int exp_lat(input int k);
`ifdef FPU_CONVERT_FAST_EN
        return 2;
`else
        return k + 2;
`endif
    endfunction

    function automatic real pow2(input int n);
        real p;
        p = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) p = p * 2.0;
        else for (int i = 0; i < -n; i++) p = p / 2.0;
        return p;
    endfunction

    function automatic longint trunc_r(input real v);
        if (v >= 16777216.0 || v <= -16777216.0) return longint'(v);
        return longint'($rtoi(v));
    endfunction

    // Reference: value-level conversion with real arithmetic, truncation toward zero.
    task automatic model(input logic op, input logic sgn, input logic [31:0] opd,
                         output logic [31:0] res, output logic exc, output int k);
        longint v, m, t;
        real    fv;
        logic [63:0] b;
        int     ex, e;
        res = 32'h0; exc = 1'b0; k = 0; t = 0;
        if (!op) begin
            v = sgn ? longint'($signed(opd)) : longint'({32'h0, opd});
            m = (v < 0) ? -v : v;
            if (m != 0) begin
                b   = $realtobits(real'(m));
                ex  = int'(b[62:52]) - 896;
                res = {(v < 0) ? 1'b1 : 1'b0, 8'(ex), b[51:29]};
                k   = 158 - ex;
            end
        end else begin
            e = int'(opd[30:23]);
            if (e == 255 && opd[22:0] != 23'h0) begin
                res = sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
                exc = 1'b1;
            end else begin
                if (e == 255) fv = 1.0e40;
                else if (e == 0) fv = real'(opd[22:0]) * pow2(-149);
                else fv = (1.0 + real'(opd[22:0]) * pow2(-23)) * pow2(e - 127);
                if (opd[31]) fv = -fv;
                if (sgn) begin
                    if (fv >= 2147483648.0) begin res = 32'h7FFF_FFFF; exc = 1'b1; end
                    else if (fv < -2147483648.0) begin res = 32'h8000_0000; exc = 1'b1; end
                    else begin t = trunc_r(fv); res = 32'(t); end
                end else begin
                    if (fv <= -1.0) begin res = 32'h0; exc = 1'b1; end
                    else if (fv >= 4294967296.0) begin res = 32'hFFFF_FFFF; exc = 1'b1; end
                    else begin t = trunc_r(fv); res = 32'(t); end
                end
                if (!exc && e >= 127 && e <= 157) k = 158 - e;
            end
        end
    endtask

    task automatic gen_vec(output logic op, output logic sgn, output logic [31:0] opd);
        logic [7:0] e;
        op  = 1'($urandom_range(0, 1));
        sgn = 1'($urandom_range(0, 1));
        if (!op) begin
            opd = $urandom() >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) opd = -opd;
        end else begin
            case ($urandom_range(0, 9))
                0:       e = 8'hFF;
                1:       e = 8'($urandom_range(0, 126));
                default: e = 8'($urandom_range(120, 162));
            endcase
            opd = {1'($urandom_range(0, 1)), e, 23'($urandom())};
            if ($urandom_range(0, 7) == 0) opd[22:0] = 23'h0;
        end
    endtask

    task automatic run_conv(input logic op, input logic sgn, input logic [31:0] opd,
                            output logic [31:0] res, output logic exc, output int lat);
        @(negedge clk);
        START = 1'b1; OP = op; SIGNED = sgn; OPERAND = opd;
        @(posedge clk);
        @(negedge clk);
        START = 1'b0;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (DONE) begin
                lat = n;
                break;
            end
        end
        res = RESULT;
        exc = EXCEPTION;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_cnt++;
        if (RESULT !== 32'h0) $display("FAIL reset_result got %h want 00000000", RESULT); else pass_cnt++;
        total_cnt++;
        if (BUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", BUSY); else pass_cnt++;
        total_cnt++;
        if (DONE !== 1'b0) $display("FAIL reset_done got %b want 0", DONE); else pass_cnt++;
        total_cnt++;
        if (EXCEPTION !== 1'b0) $display("FAIL reset_exception got %b want 0", EXCEPTION); else pass_cnt++;
    endtask

    typedef struct {
        logic        op;
        logic        sgn;
        logic [31:0] opd;
        logic [31:0] res;
        logic        exc;
        int          k;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[9];
        logic [31:0] r;
        logic        x;
        int          lat;
        tbl[0] = '{1'b0, 1'b1, 32'h0000_0001, 32'h3F80_0000, 1'b0, 31};
        tbl[1] = '{1'b0, 1'b1, 32'h8000_0000, 32'hCF00_0000, 1'b0, 0};
        tbl[2] = '{1'b0, 1'b0, 32'h8000_0000, 32'h4F00_0000, 1'b0, 0};
        tbl[3] = '{1'b1, 1'b1, 32'h4049_0FDB, 32'h0000_0003, 1'b0, 30};
        tbl[4] = '{1'b1, 1'b1, 32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 30};
        tbl[5] = '{1'b1, 1'b1, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 0};
        tbl[6] = '{1'b1, 1'b0, 32'h4F80_0000, 32'hFFFF_FFFF, 1'b1, 0};
        tbl[7] = '{1'b1, 1'b1, 32'hCF00_0000, 32'h8000_0000, 1'b0, 0};
        tbl[8] = '{1'b1, 1'b0, 32'hBFC0_0000, 32'h0000_0000, 1'b1, 0};
        for (int i = 0; i < 9; i++) begin
            run_conv(tbl[i].op, tbl[i].sgn, tbl[i].opd, r, x, lat);
            total_cnt++;
            if (r !== tbl[i].res) $display("FAIL directed[%0d] result got %h want %h", i, r, tbl[i].res); else pass_cnt++;
            total_cnt++;
            if (x !== tbl[i].exc) $display("FAIL directed[%0d] exception got %b want %b", i, x, tbl[i].exc); else pass_cnt++;
            total_cnt++;
            if (lat != exp_lat(tbl[i].k)) $display("FAIL directed[%0d] latency got %0d want %0d", i, lat, exp_lat(tbl[i].k)); else pass_cnt++;
            @(posedge clk);
            #1;
            total_cnt++;
            if (DONE !== 1'b0 || BUSY !== 1'b0) $display("FAIL directed[%0d] done_pulse done=%b busy=%b want 0 0", i, DONE, BUSY); else pass_cnt++;
            total_cnt++;
            if (RESULT !== tbl[i].res) $display("FAIL directed[%0d] result_hold got %h want %h", i, RESULT, tbl[i].res); else pass_cnt++;
        end
    endtask

    task automatic test_random(input int n_vec);
        logic op, sgn, x, ex;
        logic [31:0] opd, r, er;
        int lat, k;
        for (int i = 0; i < n_vec; i++) begin
            gen_vec(op, sgn, opd);
            model(op, sgn, opd, er, ex, k);
            run_conv(op, sgn, opd, r, x, lat);
            total_cnt++;
            if (r !== er || x !== ex)
                $display("FAIL random op=%b sgn=%b opd=%h got %h/%b want %h/%b", op, sgn, opd, r, x, er, ex);
            else pass_cnt++;
            total_cnt++;
            if (lat != exp_lat(k)) $display("FAIL random_latency opd=%h got %0d want %0d", opd, lat, exp_lat(k)); else pass_cnt++;
        end
    endtask

    task automatic test_busy_ignore();
        int dcount, lat;
        logic [31:0] r;
        @(negedge clk);
        START = 1'b1; OP = 1'b0; SIGNED = 1'b1; OPERAND = 32'h0000_0001;
        @(posedge clk);
        @(negedge clk);
        OPERAND = 32'h0000_0005;
        total_cnt++;
        if (BUSY !== 1'b1) $display("FAIL busy_after_accept got %b want 1", BUSY); else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        START = 1'b0;
        dcount = 0; lat = -1; r = 32'h0;
        for (int n = 2; n <= 45; n++) begin
            @(posedge clk);
            #1;
            if (DONE) begin
                dcount++;
                if (lat < 0) begin lat = n; r = RESULT; end
            end
        end
        total_cnt++;
        if (dcount != 1) $display("FAIL busy_ignore done_count got %0d want 1", dcount); else pass_cnt++;
        total_cnt++;
        if (r !== 32'h3F80_0000) $display("FAIL busy_ignore result got %h want 3f800000", r); else pass_cnt++;
        total_cnt++;
        if (lat != exp_lat(31)) $display("FAIL busy_ignore latency got %0d want %0d", lat, exp_lat(31)); else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        int dcount, lat;
        logic [31:0] r;
        logic x;
        @(negedge clk);
        START = 1'b1; OP = 1'b0; SIGNED = 1'b1; OPERAND = 32'h0000_0001;
        @(posedge clk);
        @(negedge clk);
        START = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        RESET = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) $display("FAIL midreset busy/done got %b/%b want 0/0", BUSY, DONE); else pass_cnt++;
        total_cnt++;
        if (RESULT !== 32'h0 || EXCEPTION !== 1'b0) $display("FAIL midreset result got %h/%b want 00000000/0", RESULT, EXCEPTION); else pass_cnt++;
        @(negedge clk);
        RESET = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (DONE) dcount++;
        end
        total_cnt++;
        if (dcount != 0) $display("FAIL midreset spurious_done got %0d want 0", dcount); else pass_cnt++;
        run_conv(1'b0, 1'b1, 32'hFFFF_FFF9, r, x, lat);
        total_cnt++;
        if (r !== 32'hC0E0_0000 || x !== 1'b0) $display("FAIL midreset fresh got %h/%b want c0e00000/0", r, x); else pass_cnt++;
        total_cnt++;
        if (lat != exp_lat(29)) $display("FAIL midreset fresh_latency got %0d want %0d", lat, exp_lat(29)); else pass_cnt++;
    endtask

    // START held high across DONE: the DONE-edge sample is ignored, the next edge accepts.
    task automatic test_back_to_back();
        logic op[6], sgn[6], ex[6];
        logic [31:0] opd[6], er[6];
        int k[6];
        int gap;
        for (int i = 0; i < 6; i++) begin
            gen_vec(op[i], sgn[i], opd[i]);
            model(op[i], sgn[i], opd[i], er[i], ex[i], k[i]);
        end
        @(negedge clk);
        START = 1'b1; OP = op[0]; SIGNED = sgn[0]; OPERAND = opd[0];
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            gap = -1;
            for (int n = 1; n <= 60; n++) begin
                #1;
                if (n > 1 || i == 0) begin
                    @(posedge clk);
                    #1;
                end else begin
                    @(posedge clk);
                    #1;
                end
                if (DONE) begin gap = n; break; end
            end
            if (i < 5) begin
                OP = op[i + 1]; SIGNED = sgn[i + 1]; OPERAND = opd[i + 1];
            end else begin
                START = 1'b0;
            end
            total_cnt++;
            if (RESULT !== er[i] || EXCEPTION !== ex[i])
                $display("FAIL b2b[%0d] opd=%h got %h/%b want %h/%b", i, opd[i], RESULT, EXCEPTION, er[i], ex[i]);
            else pass_cnt++;
            total_cnt++;
            if (gap != exp_lat(k[i]) + ((i == 0) ? 0 : 1))
                $display("FAIL b2b[%0d] spacing got %0d want %0d", i, gap, exp_lat(k[i]) + ((i == 0) ? 0 : 1));
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        RESET = 1'b0;
        test_reset();
        test_directed();
        test_random(120);
        test_busy_ignore();
        test_reset_midflight();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
